sevenseg_scan: RTL

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a packed hexadecimal value and steps through the digits one at a time. For each digit it presents the 4-bit nibble to the downstream `sevenseg` decoder and drives the matching digit-select line. It sits directly upstream of `sevenseg`: `nibble_o` feeds the decoder input, and `seg_en_o` gates the decoder's segment outputs at the top level.

---
 rtl/sevenseg_pkg.sv | 33 +++
 rtl/sevenseg_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types, constants and blank-mask helper for the seven-segment scanner
package sevenseg_pkg;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } scan_state_t;

    // Bit k set when digit k is a leading zero: digits k..nd-1 all zero and k>0.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [NIB_W*MAX_DIGITS-1:0] v,
        input int                          nd
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < nd) begin
                if (v[k*NIB_W +: NIB_W] != '0) begin
                    seen = 1'b1;
                end
                mask[k] = !seen && (k != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - time-multiplexed digit scan controller for a common-anode display
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000,
    parameter int DEADTIME = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic [NIB_W*NDIGITS-1:0] value_i,
    input  logic                     load_i,
    output logic [NIB_W-1:0]         nibble_o,
    output logic [NDIGITS-1:0]       digit_sel_n_o,
    output logic                     seg_en_o,
    output logic                     frame_o
);

    localparam int CNT_MAX   = (PRESCALE > DEADTIME) ? PRESCALE : DEADTIME;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int IDX_W     = $clog2(NDIGITS);
    localparam int DEAD_LAST = (DEADTIME > 0) ? DEADTIME - 1 : 0;

    scan_state_t                state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NIB_W*NDIGITS-1:0]   active_q, active_d;
    logic [NIB_W*NDIGITS-1:0]   shadow_q, shadow_d;
    logic                       pending_q, pending_d;
    logic                       frame_d;
    logic                       advance;

    logic [NIB_W*MAX_DIGITS-1:0] padded;
    logic [MAX_DIGITS-1:0]       blank_mask;
    logic                        lit_d;
    logic [NIB_W-1:0]            nibble_d;
    logic [NDIGITS-1:0]          sel_n_d;

    // Next-state: scan sequencing, frame wrap and double-buffered value update
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        advance   = 1'b0;
        if (state_q == IDLE) begin
            // While dark there is no frame to tear, so loads apply at once.
            if (load_i) begin
                active_d  = value_i;
                pending_d = 1'b0;
            end
            if (enable_i) begin
                state_d = DRIVE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        end else if (!enable_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            if (load_i) begin
                shadow_d  = value_i;
                pending_d = 1'b1;
            end
        end else begin
            if (state_q == DRIVE) begin
                if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                    cnt_d = '0;
                    if (DEADTIME > 0) begin
                        state_d = DEAD;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == CNT_W'(DEAD_LAST)) begin
                    cnt_d   = '0;
                    state_d = DRIVE;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (advance) begin
                if (idx_q == IDX_W'(NDIGITS - 1)) begin
                    idx_d   = '0;
                    frame_d = 1'b1;
                    if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // A load on the wrap edge lands in shadow after the swap above,
            // so it waits for the following boundary.
            if (load_i) begin
                shadow_d  = value_i;
                pending_d = 1'b1;
            end
        end
    end

    // Output decode from next-state so the registered outputs line up with state/idx
    always_comb begin
        padded                     = '0;
        padded[NIB_W*NDIGITS-1:0]  = active_d;
        blank_mask                 = lz_mask(padded, NDIGITS);
        lit_d    = (state_d == DRIVE) && !((BLANK_LZ != 0) && blank_mask[idx_d]);
        nibble_d = lit_d ? active_d[{idx_d, 2'b00} +: NIB_W] : '0;
        sel_n_d  = lit_d ? ~(NDIGITS'(1) << idx_d) : '1;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            nibble_o      <= '0;
            digit_sel_n_o <= '1;
            seg_en_o      <= 1'b0;
            frame_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            nibble_o      <= nibble_d;
            digit_sel_n_o <= sel_n_d;
            seg_en_o      <= lit_d;
            frame_o       <= frame_d;
        end
    end

endmodule
